// File: rtl/bcd_counter_n_pkg.sv
// Shared definitions for the BCD counter.
// Contents:
//   bcd_t      - one BCD digit (4 bits)
//   BCD_MAX    - largest legal digit value (9)
//   SEG_BLANK  - active-low pattern with every segment off
//   bcd_to_seg - digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}
package bcd_counter_n_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t       BCD_MAX   = 4'd9;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low decode; any non-BCD code shows blank.
   function automatic logic [6:0] bcd_to_seg(input bcd_t d);
      logic [6:0] seg;
      case (d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_counter_n_digit_cell.sv
// One BCD digit of the counter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr, load   - synchronous clear / load (clr wins)
//   load_digit  - value to load; codes above 9 are stored as 0
//   tick        - count event from the prescaler
//   dir         - 0 = up, 1 = down
//   step_in     - all lower digits are at 9 (up) or 0 (down)
//   hold        - whole counter saturated at its bound; suppress the step
//   digit       - registered digit value
//   step_out    - step_in and this digit is also at 9 (up) / 0 (down)
module bcd_digit_cell
   import bcd_counter_n_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic load,
   input  bcd_t load_digit,
   input  logic tick,
   input  logic dir,
   input  logic step_in,
   input  logic hold,
   output bcd_t digit,
   output logic step_out
);

   bcd_t digit_r;
   bcd_t digit_next_s;

   assign step_out = step_in & (dir ? (digit_r == 4'd0) : (digit_r == BCD_MAX));
   assign digit    = digit_r;

   // Next digit value: clr > load > tick.
   always_comb begin
      digit_next_s = digit_r;
      if (clr) begin
         digit_next_s = 4'd0;
      end else if (load) begin
         digit_next_s = (load_digit > BCD_MAX) ? 4'd0 : load_digit;
      end else if (tick && step_in && !hold) begin
         if (dir) begin
            digit_next_s = (digit_r == 4'd0) ? BCD_MAX : digit_r - 4'd1;
         end else begin
            digit_next_s = (digit_r == BCD_MAX) ? 4'd0 : digit_r + 4'd1;
         end
      end else begin
         digit_next_s = digit_r;
      end
   end

   // Digit register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_r <= 4'd0;
      end else begin
         digit_r <= digit_next_s;
      end
   end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with prescaler, wrap/saturate, load,
// terminal-count pulse and active-low 7-segment outputs.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear of digits, prescaler and tc
//   en         - prescaler runs when 1; everything holds when 0
//   fast       - tick at twice the normal rate
//   dir        - 0 = up, 1 = down
//   sat        - 0 = wrap at bound, 1 = hold at bound
//   load       - synchronous load strobe, load_val digit 0 in [3:0]
//   blank_lz   - blank leading zeros (digit 0 is never blanked)
//   digits     - registered BCD count
//   tc         - registered one-cycle pulse on a tick at bound
//   hex        - active-low segments, hex[i] for digit i
module bcd_counter_n
   import bcd_counter_n_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_HZ     = 50000000,
   parameter int TICK_HZ    = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr,
   input  logic                           en,
   input  logic                           fast,
   input  logic                           dir,
   input  logic                           sat,
   input  logic                           load,
   input  logic [4*NUM_DIGITS-1:0]        load_val,
   input  logic                           blank_lz,
   output logic [4*NUM_DIGITS-1:0]        digits,
   output logic                           tc,
   output logic [NUM_DIGITS-1:0][6:0]     hex
);

   localparam int PERIOD = CLK_HZ / TICK_HZ;
   localparam int HALF   = PERIOD / 2;
   localparam int CNT_W  = $clog2(PERIOD + 1);

   localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);

   logic [CNT_W-1:0]      presc_r;
   logic                  tick_s;
   logic                  hold_s;
   logic                  tc_r;
   logic [NUM_DIGITS:0]   step_s;
   logic [4*NUM_DIGITS-1:0] digits_s;

   // With fast=1 the ">=" catches a prescaler already past HALF-1 when fast rises.
   assign tick_s = en & (fast ? (presc_r >= HALF_M1) : (presc_r == PERIOD_M1));

   // step_s[NUM_DIGITS] is the full carry/borrow chain: the counter is at its bound.
   assign step_s[0] = 1'b1;
   assign hold_s    = sat & step_s[NUM_DIGITS];

   // Prescaler: restarts on clr/load and after every tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= '0;
      end else if (clr || load) begin
         presc_r <= '0;
      end else if (tick_s) begin
         presc_r <= '0;
      end else if (en) begin
         presc_r <= presc_r + CNT_W'(1);
      end else begin
         presc_r <= presc_r;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         bcd_digit_cell u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .load       (load),
            .load_digit (load_val[4*gi +: 4]),
            .tick       (tick_s),
            .dir        (dir),
            .step_in    (step_s[gi]),
            .hold       (hold_s),
            .digit      (digits_s[4*gi +: 4]),
            .step_out   (step_s[gi+1])
         );
      end
   endgenerate

   // Terminal count pulse, updated on the same edge as the digits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tc_r <= 1'b0;
      end else if (clr || load) begin
         tc_r <= 1'b0;
      end else begin
         tc_r <= tick_s & step_s[NUM_DIGITS];
      end
   end

   assign digits = digits_s;
   assign tc     = tc_r;

   // Segment decode with leading-zero blanking, scanned from the top digit down.
   always_comb begin
      logic upper_nz;
      upper_nz = 1'b0;
      hex      = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_nz = upper_nz | (digits_s[4*i +: 4] != 4'd0);
         if (blank_lz && (i != 0) && !upper_nz) begin
            hex[i] = SEG_BLANK;
         end else begin
            hex[i] = bcd_to_seg(digits_s[4*i +: 4]);
         end
      end
   end

endmodule

// File: tb/tb_bcd_counter_n.sv
module tb_bcd_counter_n;

   localparam logic [6:0] SEG0 = 7'b1000000;
   localparam logic [6:0] SEG3 = 7'b0110000;
   localparam logic [6:0] SEG4 = 7'b0011001;
   localparam logic [6:0] BLNK = 7'b1111111;

   logic              clk = 1'b0;
   logic              rst_n, clr, en, fast, dir, sat, load, blank_lz;
   logic [15:0]       load_val;
   logic [15:0]       digits;
   logic              tc;
   logic [3:0][6:0]   hex;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bcd_counter_n #(.NUM_DIGITS(4), .CLK_HZ(10), .TICK_HZ(1)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .fast(fast), .dir(dir),
      .sat(sat), .load(load), .load_val(load_val), .blank_lz(blank_lz),
      .digits(digits), .tc(tc), .hex(hex)
   );

   // Advance n rising edges, ending 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1; load_val = v;
      step(1);
      load = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=0000", digits); end
      checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
      checks++; if (hex[0] !== SEG0) begin failures++; $display("FAIL reset_hex0 got=%b exp=%b", hex[0], SEG0); end
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_count_up();
      en = 1'b1; dir = 1'b0;
      step(9);
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL up_c9 got=%h exp=0000", digits); end
      step(1);
      checks++; if (digits !== 16'h0001) begin failures++; $display("FAIL up_c10 got=%h exp=0001", digits); end
      step(10);
      checks++; if (digits !== 16'h0002) begin failures++; $display("FAIL up_c20 got=%h exp=0002", digits); end
      step(10);
      checks++; if (digits !== 16'h0003) begin failures++; $display("FAIL up_c30 got=%h exp=0003", digits); end
      checks++; if (hex[0] !== SEG3) begin failures++; $display("FAIL up_hex0 got=%b exp=%b", hex[0], SEG3); end
      en = 1'b0;
      step(15);
      checks++; if (digits !== 16'h0003) begin failures++; $display("FAIL en_hold got=%h exp=0003", digits); end
      do_clr();
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL clr got=%h exp=0000", digits); end
   endtask

   task automatic test_wrap_sat_up();
      en = 1'b1; dir = 1'b0; sat = 1'b0;
      do_load(16'h9999);
      step(9);
      checks++; if (digits !== 16'h9999 || tc !== 1'b0) begin failures++; $display("FAIL wrap_pre got=%h/%b exp=9999/0", digits, tc); end
      step(1);
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL wrap_digits got=%h exp=0000", digits); end
      checks++; if (tc !== 1'b1) begin failures++; $display("FAIL wrap_tc got=%b exp=1", tc); end
      step(1);
      checks++; if (tc !== 1'b0) begin failures++; $display("FAIL wrap_tc_len got=%b exp=0", tc); end
      sat = 1'b1;
      do_load(16'h9999);
      step(10);
      checks++; if (digits !== 16'h9999 || tc !== 1'b1) begin failures++; $display("FAIL sat1 got=%h/%b exp=9999/1", digits, tc); end
      step(1);
      checks++; if (tc !== 1'b0) begin failures++; $display("FAIL sat_tc_len got=%b exp=0", tc); end
      step(9);
      checks++; if (digits !== 16'h9999 || tc !== 1'b1) begin failures++; $display("FAIL sat2 got=%h/%b exp=9999/1", digits, tc); end
      sat = 1'b0;
   endtask

   task automatic test_count_down();
      en = 1'b1; dir = 1'b1; sat = 1'b0;
      do_load(16'h1000);
      step(10);
      checks++; if (digits !== 16'h0999) begin failures++; $display("FAIL down_borrow got=%h exp=0999", digits); end
      do_load(16'h0000);
      step(10);
      checks++; if (digits !== 16'h9999 || tc !== 1'b1) begin failures++; $display("FAIL down_wrap got=%h/%b exp=9999/1", digits, tc); end
      // direction change applies on the very next tick
      dir = 1'b0;
      do_load(16'h0005);
      step(10);
      checks++; if (digits !== 16'h0006) begin failures++; $display("FAIL dir_up got=%h exp=0006", digits); end
      dir = 1'b1;
      step(10);
      checks++; if (digits !== 16'h0005) begin failures++; $display("FAIL dir_down got=%h exp=0005", digits); end
      dir = 1'b0;
   endtask

   task automatic test_fast();
      en = 1'b1; dir = 1'b0; fast = 1'b0;
      do_clr();
      step(7);
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL fast_pre got=%h exp=0000", digits); end
      fast = 1'b1;
      step(1);
      checks++; if (digits !== 16'h0001) begin failures++; $display("FAIL fast_first got=%h exp=0001", digits); end
      step(4);
      checks++; if (digits !== 16'h0001) begin failures++; $display("FAIL fast_c4 got=%h exp=0001", digits); end
      step(1);
      checks++; if (digits !== 16'h0002) begin failures++; $display("FAIL fast_c5 got=%h exp=0002", digits); end
      step(5);
      checks++; if (digits !== 16'h0003) begin failures++; $display("FAIL fast_c10 got=%h exp=0003", digits); end
      fast = 1'b0;
   endtask

   task automatic test_priority();
      en = 1'b0;
      do_load(16'h4321);
      clr = 1'b1; load = 1'b1; load_val = 16'h1234;
      step(1);
      clr = 1'b0; load = 1'b0;
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL clr_over_load got=%h exp=0000", digits); end
      do_load(16'h00A5);
      checks++; if (digits !== 16'h0005) begin failures++; $display("FAIL load_invalid got=%h exp=0005", digits); end
      do_load(16'h3F0C);
      checks++; if (digits !== 16'h3000) begin failures++; $display("FAIL load_invalid2 got=%h exp=3000", digits); end
   endtask

   task automatic test_blank();
      en = 1'b0; blank_lz = 1'b1;
      do_load(16'h0040);
      checks++; if (hex[3] !== BLNK || hex[2] !== BLNK) begin failures++; $display("FAIL blank_hi got=%b,%b exp=%b", hex[3], hex[2], BLNK); end
      checks++; if (hex[1] !== SEG4) begin failures++; $display("FAIL blank_hex1 got=%b exp=%b", hex[1], SEG4); end
      checks++; if (hex[0] !== SEG0) begin failures++; $display("FAIL blank_hex0 got=%b exp=%b", hex[0], SEG0); end
      do_load(16'h0000);
      checks++; if (hex[1] !== BLNK || hex[0] !== SEG0) begin failures++; $display("FAIL blank_zero got=%b,%b exp=%b,%b", hex[1], hex[0], BLNK, SEG0); end
      do_load(16'h4000);
      checks++; if (hex[2] !== SEG0 || hex[0] !== SEG0) begin failures++; $display("FAIL blank_inner got=%b,%b exp=%b,%b", hex[2], hex[0], SEG0, SEG0); end
      blank_lz = 1'b0;
      do_load(16'h0040);
      checks++; if (hex[3] !== SEG0) begin failures++; $display("FAIL noblank_hex3 got=%b exp=%b", hex[3], SEG0); end
   endtask

   task automatic test_reset_mid_period();
      en = 1'b1; dir = 1'b0;
      do_load(16'h0007);
      step(3);
      rst_n = 1'b0;
      #2;
      checks++; if (digits !== 16'h0000 || tc !== 1'b0) begin failures++; $display("FAIL async_rst got=%h/%b exp=0000/0", digits, tc); end
      checks++; if (hex[0] !== SEG0) begin failures++; $display("FAIL async_rst_hex0 got=%b exp=%b", hex[0], SEG0); end
      #2;
      rst_n = 1'b1;
      step(9);
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL rst_partial got=%h exp=0000", digits); end
      step(1);
      checks++; if (digits !== 16'h0001) begin failures++; $display("FAIL rst_first_tick got=%h exp=0001", digits); end
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; en = 1'b0; fast = 1'b0; dir = 1'b0;
      sat = 1'b0; load = 1'b0; load_val = 16'h0000; blank_lz = 1'b0;
      test_reset();
      test_count_up();
      test_wrap_sat_up();
      test_count_down();
      test_fast();
      test_priority();
      test_blank();
      test_reset_mid_period();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of BCD digits, range 1..8.
REQ-002 SHALL have parameter CLK_HZ, default 50000000: input clock frequency.
REQ-003 SHALL have parameter TICK_HZ, default 1: normal count rate; PERIOD = CLK_HZ/TICK_HZ, HALF = PERIOD/2, HALF >= 1.
REQ-004 SHALL have port clk, input, 1: single clock, all state on posedge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clr, input, 1: synchronous clear of digits and prescaler.
REQ-007 SHALL have port en, input, 1: 1 = prescaler runs; 0 = prescaler and digits hold.
REQ-008 SHALL have port fast, input, 1: 1 = count at twice TICK_HZ.
REQ-009 SHALL have port dir, input, 1: 0 = up, 1 = down.
REQ-010 SHALL have port sat, input, 1: 0 = wrap at bound; 1 = saturate at bound.
REQ-011 SHALL have port load, input, 1: synchronous load strobe.
REQ-012 SHALL have port load_val, input, 4*NUM_DIGITS: BCD load value, digit 0 in bits [3:0].
REQ-013 SHALL have port blank_lz, input, 1: 1 = blank leading zeros.
REQ-014 SHALL have port digits, output, 4*NUM_DIGITS: registered BCD count, digit 0 least significant.
REQ-015 SHALL have port tc, output, 1: registered one-cycle terminal-count pulse.
REQ-016 SHALL have port hex, output, NUM_DIGITS x 7: active-low segment patterns, hex[i] for digit i.

Function
REQ-017 The prescaler SHALL count 0..PERIOD-1 while en=1 and assert internal tick in the cycle where it equals PERIOD-1, then return to 0.
REQ-018 With fast=1, the prescaler SHALL assert tick and return to 0 when its value >= HALF-1, including when fast rises mid-period.
REQ-019 Priority SHALL be rst_n > clr > load > tick; a lower-priority event in the same cycle is discarded.
REQ-020 On clr, digits SHALL become 0, the prescaler SHALL become 0, and tc SHALL be 0 next cycle.
REQ-021 On load, digits SHALL take load_val, any digit > 9 SHALL be stored as 0, and the prescaler SHALL become 0.
REQ-022 On tick with dir=0, digit i SHALL increment if all lower digits equal 9; a 9 that increments SHALL become 0.
REQ-023 On tick with dir=1, digit i SHALL decrement if all lower digits equal 0; a 0 that decrements SHALL become 9.
REQ-024 Bound SHALL be all-9 for up and all-0 for down; a tick at bound SHALL pulse tc for exactly one cycle, aligned with the digits update edge.
REQ-025 At bound with sat=0, digits SHALL wrap (all-9 to all-0, all-0 to all-9).
REQ-026 At bound with sat=1, digits SHALL hold, and tc SHALL still pulse on each tick.
REQ-027 A change of dir SHALL take effect on the next tick with no extra step.
REQ-028 hex SHALL be combinational from digits, giving zero added latency beyond the digits register.
REQ-029 With blank_lz=1, hex[i] for i>0 SHALL be 7'b1111111 when digit i and all higher digits are 0; hex[0] SHALL never be blanked.

Reset
REQ-030 While rst_n=0, digits, prescaler and tc SHALL be 0 asynchronously, so hex shows "0" on digit 0.
REQ-031 After rst_n deasserts, the first tick SHALL occur PERIOD (or HALF with fast=1) enabled cycles later.
REQ-032 Reset mid-period SHALL discard the partial prescaler count.

Structure
REQ-033 A shared package SHALL hold the bcd_t type (4-bit), the constants BCD_MAX=9 and SEG_BLANK=7'b1111111, and the digit-to-segment function.
REQ-034 One sub-module, bcd_digit_cell (one digit with inc/dec, borrow/carry in/out, load), SHALL be instantiated NUM_DIGITS times via generate.

Verification (NUM_DIGITS=4, CLK_HZ=10, TICK_HZ=1: PERIOD=10, HALF=5)
REQ-035 Reset then en=1, dir=0, 30 cycles -> digits 0001, 0002, 0003 at cycles 10, 20, 30; hex[0] shows "3" at the end.
REQ-036 Load 9999, dir=0, sat=0, wait one tick -> digits 0000 and tc high for exactly 1 cycle; with sat=1 instead -> digits 9999 and tc pulses again.
REQ-037 Load 1000, dir=1, one tick -> digits 0999; load 0000, dir=1, sat=0 -> 9999 with tc pulse.
REQ-038 fast=1 asserted when prescaler=7 -> tick next cycle, then ticks every 5 cycles.
REQ-039 load and clr in the same cycle -> digits 0000; load_val 0x00A5 -> digits 0005 (digit 1 value A replaced by 0).
REQ-040 blank_lz=1 with digits 0040 -> hex[3], hex[2] blank; hex[1] shows "4"; hex[0] shows "0"; rst_n pulsed mid-period -> all outputs 0 immediately.
